// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for serial_subtractor.
// master: start, a, b out; busy, done, diff, bout (ovf with SERIAL_SUB_OVF_EN) in.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  diff,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  bout
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output diff,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock, single borrow flop.
// Ports: clk, rst (async, active-high), bus (slave): start, a, b -> busy, done,
// diff, bout; ovf (signed overflow) only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             nbrw;
`ifdef SERIAL_SUB_OVF_EN
    // operand sign bits, kept because sa/sb are shifted away
    logic             am;
    logic             bm;
`endif

    always_comb begin
        d    = sa[0] ^ sb[0] ^ brw;
        nbrw = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            brw      <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.diff <= '0;
            bus.bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            am       <= 1'b0;
            bm       <= 1'b0;
            bus.ovf  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa       <= bus.a;
                        sb       <= bus.b;
                        res      <= '0;
                        brw      <= 1'b0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        am       <= bus.a[WIDTH-1];
                        bm       <= bus.b[WIDTH-1];
`endif
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    brw <= nbrw;
                    res <= {d, res[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    // last bit: publish the fully shifted result directly
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.diff <= {d, res[WIDTH-1:1]};
                        bus.bout <= nbrw;
`ifdef SERIAL_SUB_OVF_EN
                        bus.ovf  <= (am ^ bm) & (d ^ am);
`endif
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
